fetch_prefetch: RTL and testbench

//  Parametrised instruction fetch unit with in-order prefetch queue and pipelined imem req/gnt/rvalid port.

---
 rtl/fetch_prefetch_if.sv | 14 +
 rtl/fetch_prefetch.sv | 105 ++++++++++
 tb/tb_fetch_prefetch.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and memory (slave).
// Requests are req/gnt handshaked; responses return in issue order on rvalid.
interface fetch_prefetch_if #(
  parameter int XLEN = 32
) ();
  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_prefetch.sv
// Instruction fetch unit: in-order prefetch queue over a pipelined imem port, with
// redirect flush and a drop counter that discards responses to stale requests.
module fetch_prefetch #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH       = 4,
  parameter logic [XLEN-1:0] RESET_ADDR  = '0,
  parameter logic [XLEN-1:0] EXCEPT_ADDR = XLEN'(32'h0000_0008),
  parameter logic [XLEN-1:0] ILLOP_ADDR  = XLEN'(32'h0000_0004),
  parameter logic [XLEN-1:0] NOP_INST    = XLEN'(32'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_prefetch_if.master  imem,
  input  logic              i_irq,
  input  logic              i_ill_op,
  input  logic              i_redirect_en,
  input  logic [XLEN-1:0]   i_redirect_addr,
  input  logic              i_inst_ready,
  output logic              o_inst_valid,
  output logic [XLEN-1:0]   o_inst,
  output logic [XLEN-1:0]   o_inst_pc,
  output logic [XLEN-1:0]   o_pc_plus_four
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic            r_started;
  logic [XLEN-1:0] r_fetch_pc, r_rsp_pc, r_tgt_pc;
  logic [CW-1:0]   r_cnt, r_out, r_drop;
  logic [AW-1:0]   r_wr, r_rd;
  logic [XLEN-1:0] r_q_inst [DEPTH];
  logic [XLEN-1:0] r_q_pc   [DEPTH];

  logic            w_redir, w_issue, w_rsp_drop, w_rsp_keep, w_push, w_pop, w_drain_block;
  logic [CW-1:0]   w_occ;
  logic [XLEN-1:0] w_target;

  assign w_redir       = i_irq | i_ill_op | i_redirect_en;
  assign w_target      = i_irq ? EXCEPT_ADDR : (i_ill_op ? ILLOP_ADDR : i_redirect_addr);
  assign w_occ         = CW'(r_cnt + r_out);
  // Worst case drop after a redirect is (DEPTH-1) + DEPTH, which still fits in CW bits.
  assign w_drain_block = r_drop >= CW'(DEPTH);

  assign imem.req  = r_started & (w_occ < CW'(DEPTH)) & ~w_drain_block;
  assign imem.addr = r_fetch_pc;

  assign w_issue    = imem.req & imem.gnt;
  assign w_rsp_drop = imem.rvalid & (r_drop != '0);
  // An rvalid with nothing outstanding is a protocol violation and is ignored.
  assign w_rsp_keep = imem.rvalid & (r_drop == '0) & (r_out != '0);
  assign w_push     = w_rsp_keep & ~w_redir;

  assign o_inst_valid   = r_cnt != '0;
  assign w_pop          = o_inst_valid & i_inst_ready & ~w_redir;
  assign o_inst         = o_inst_valid ? r_q_inst[r_rd] : NOP_INST;
  assign o_inst_pc      = o_inst_valid ? r_q_pc[r_rd] : r_tgt_pc;
  assign o_pc_plus_four = o_inst_pc + XLEN'(4);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_started  <= 1'b0;
      r_fetch_pc <= RESET_ADDR;
      r_rsp_pc   <= RESET_ADDR;
      r_tgt_pc   <= RESET_ADDR;
      r_cnt      <= '0;
      r_out      <= '0;
      r_drop     <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
    end else begin
      r_started <= 1'b1;
      if (w_redir) begin
        r_fetch_pc <= w_target;
        r_rsp_pc   <= w_target;
        r_tgt_pc   <= w_target;
        r_cnt      <= '0;
        r_wr       <= '0;
        r_rd       <= '0;
        r_out      <= '0;
        // everything still in flight, including this cycle's grant, becomes stale
        r_drop     <= r_drop - CW'(w_rsp_drop) + r_out + CW'(w_issue) - CW'(w_rsp_keep);
      end else begin
        if (w_issue) r_fetch_pc <= r_fetch_pc + XLEN'(4);
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + XLEN'(4);
          r_wr     <= r_wr + AW'(1);
        end
        if (w_pop) r_rd <= r_rd + AW'(1);
        r_cnt  <= r_cnt + CW'(w_push) - CW'(w_pop);
        r_out  <= r_out + CW'(w_issue) - CW'(w_rsp_keep);
        r_drop <= r_drop - CW'(w_rsp_drop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_q_inst[r_wr] <= imem.rdata;
      r_q_pc[r_wr]   <= r_rsp_pc;
    end
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem.rvalid && r_out == '0 && r_drop == '0));
endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: random-latency in-order memory model plus a sequential-PC
// consumer model; a second instance with RESET_ADDR near the top checks address wrap.
module tb_fetch_prefetch;
  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h8000_0000;
  localparam logic [31:0] EXC = 32'h8;
  localparam logic [31:0] ILL = 32'h4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_prefetch_if #(.XLEN(XLEN)) mif ();
  fetch_prefetch_if #(.XLEN(XLEN)) wif ();

  logic        irq = 0, ill = 0, ren = 0, ready = 0;
  logic [31:0] raddr = 0;
  logic        valid;
  logic [31:0] inst, ipc, pp4;
  logic        w_valid;
  logic [31:0] w_inst, w_pc, w_pp4;

  fetch_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem(mif),
    .i_irq(irq), .i_ill_op(ill), .i_redirect_en(ren), .i_redirect_addr(raddr),
    .i_inst_ready(ready), .o_inst_valid(valid), .o_inst(inst), .o_inst_pc(ipc),
    .o_pc_plus_four(pp4));

  fetch_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_ADDR(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem(wif),
    .i_irq(1'b0), .i_ill_op(1'b0), .i_redirect_en(1'b0), .i_redirect_addr(32'h0),
    .i_inst_ready(1'b1), .o_inst_valid(w_valid), .o_inst(w_inst), .o_inst_pc(w_pc),
    .o_pc_plus_four(w_pp4));

  // zero-wait memory for the wrap instance: data = address
  assign wif.gnt = 1'b1;
  always @(posedge clk) begin
    wif.rvalid <= rst_n & wif.req;
    wif.rdata  <= wif.addr;
  end

  logic [31:0] wcap_pc [3];
  logic [31:0] wcap_inst [3];
  logic [31:0] wcap_pp4 [3];
  int wcnt = 0;
  always @(negedge clk) begin
    if (rst_n && w_valid && wcnt < 3) begin
      wcap_pc[wcnt] = w_pc;
      wcap_inst[wcnt] = w_inst;
      wcap_pp4[wcnt] = w_pp4;
      wcnt = wcnt + 1;
    end
  end

  typedef struct { logic [31:0] addr; int rdy; } pend_t;
  pend_t       pend[$];
  logic [31:0] iss_addr[$];
  int          n_chk = 0, n_pass = 0;
  int          cyc = 0, pops = 0;
  logic [31:0] exp_pc = 0, last_pop_pc = 0;
  int          p_gnt = 0, lat_lo = 1, lat_hi = 1, p_ready = 0, p_redir = 0;
  logic        nx_irq = 0, nx_ill = 0, nx_en = 0;
  logic [31:0] nx_addr = 0;
  logic        pv_req = 0, pv_gnt = 0, pv_redir = 0;
  logic [31:0] pv_addr = 0;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'h3C5A_96E1;
  endfunction

  // One clock of stimulus at the negedge; the model predicts what the next posedge commits.
  task automatic cycle();
    logic redir;
    @(negedge clk);
    cyc++;
    if (pv_req && !pv_gnt && !pv_redir) begin
      n_chk++;
      if (mif.req !== 1'b1 || mif.addr !== pv_addr)
        $display("FAIL req_stable cyc=%0d req=%b addr=%h want req=1 addr=%h", cyc, mif.req, mif.addr, pv_addr);
      else n_pass++;
    end
    if (pend.size() > 0 && pend[0].rdy <= cyc) begin
      mif.rvalid = 1'b1;
      mif.rdata  = f(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      mif.rvalid = 1'b0;
      mif.rdata  = $urandom;
    end
    irq = nx_irq; ill = nx_ill; ren = nx_en; raddr = nx_addr;
    nx_irq = 0; nx_ill = 0; nx_en = 0;
    if ($urandom_range(99) < p_redir) begin
      irq = ($urandom_range(3) == 0);
      ill = ($urandom_range(2) == 0);
      ren = 1'b1;
      raddr = $urandom & 32'h0000_FFFC;
    end
    mif.gnt = ($urandom_range(99) < p_gnt);
    ready   = ($urandom_range(99) < p_ready);
    if (mif.req && mif.gnt) begin
      pend.push_back('{mif.addr, cyc + int'($urandom_range(lat_hi, lat_lo))});
      iss_addr.push_back(mif.addr);
    end
    redir = irq | ill | ren;
    if (!valid) begin
      n_chk++;
      if (inst !== NOP) $display("FAIL empty_nop cyc=%0d inst=%h want %h", cyc, inst, NOP);
      else n_pass++;
    end else if (ready && !redir) begin
      n_chk++;
      if (ipc !== exp_pc || inst !== f(exp_pc) || pp4 !== exp_pc + 32'd4)
        $display("FAIL pop cyc=%0d pc=%h inst=%h pp4=%h want pc=%h inst=%h pp4=%h",
                 cyc, ipc, inst, pp4, exp_pc, f(exp_pc), exp_pc + 32'd4);
      else n_pass++;
      pops++;
      last_pop_pc = ipc;
      exp_pc = exp_pc + 32'd4;
    end
    if (redir) exp_pc = irq ? EXC : (ill ? ILL : raddr);
    pv_req = mif.req; pv_gnt = mif.gnt; pv_redir = redir; pv_addr = mif.addr;
  endtask

  // Let memory return everything, drain the queue, then redirect to 0 with no grant.
  task automatic quiesce();
    int k;
    p_gnt = 0; p_ready = 100; p_redir = 0;
    k = 0;
    do begin cycle(); k++; end while (k < 200 && !(pend.size() == 0 && !valid));
    n_chk++;
    if (k >= 200) $display("FAIL quiesce_timeout pend=%0d valid=%b want 0/0", pend.size(), valid);
    else n_pass++;
    nx_en = 1; nx_addr = 32'h0;
    cycle();
  endtask

  task automatic test_reset();
    rst_n = 0; mif.gnt = 0; mif.rvalid = 0; mif.rdata = 0; ready = 0;
    repeat (3) begin
      @(negedge clk);
      n_chk++;
      if (mif.req !== 1'b0 || valid !== 1'b0 || inst !== NOP || ipc !== 32'h0)
        $display("FAIL reset req=%b valid=%b inst=%h pc=%h want 0/0/%h/0", mif.req, valid, inst, ipc, NOP);
      else n_pass++;
    end
    rst_n = 1;
    pend.delete(); iss_addr.delete();
    exp_pc = 32'h0; pv_req = 0; pv_gnt = 0; pv_redir = 0;
  endtask

  task automatic test_stream();
    int p0;
    p_gnt = 100; lat_lo = 1; lat_hi = 1; p_ready = 100; p_redir = 0;
    cycle();
    n_chk++;
    if (mif.req !== 1'b1 || mif.addr !== 32'h0)
      $display("FAIL first_req req=%b addr=%h want 1/0", mif.req, mif.addr);
    else n_pass++;
    cycle();
    n_chk++;
    if (valid !== 1'b0) $display("FAIL lat_early valid=%b want 0", valid);
    else n_pass++;
    p0 = pops;
    cycle();
    n_chk++;
    if (valid !== 1'b1 || pops != p0 + 1) $display("FAIL lat_first valid=%b want 1", valid);
    else n_pass++;
    repeat (10) cycle();
    n_chk++;
    if (pops != p0 + 11 || last_pop_pc !== 32'h28)
      $display("FAIL stream_rate pops=%0d last=%h want %0d/00000028", pops - p0, last_pop_pc, 11);
    else n_pass++;
  endtask

  task automatic test_full();
    logic [31:0] want;
    quiesce();
    p_gnt = 100; lat_lo = 1; lat_hi = 1; p_ready = 0;
    iss_addr.delete();
    repeat (10) cycle();
    n_chk++;
    if (iss_addr.size() != DEPTH || mif.req !== 1'b0)
      $display("FAIL full_issues got=%0d req=%b want %0d/0", iss_addr.size(), mif.req, DEPTH);
    else n_pass++;
    for (int i = 0; i < iss_addr.size() && i < DEPTH; i++) begin
      want = 32'(i * 4);
      n_chk++;
      if (iss_addr[i] !== want) $display("FAIL full_addr%0d got=%h want %h", i, iss_addr[i], want);
      else n_pass++;
    end
    p_ready = 100; cycle(); p_ready = 0;
    iss_addr.delete();
    repeat (6) cycle();
    n_chk++;
    if (iss_addr.size() != 1 || iss_addr[0] !== 32'h10)
      $display("FAIL full_resume got=%0d addr=%h want 1/00000010", iss_addr.size(),
               iss_addr.size() > 0 ? iss_addr[0] : 32'hx);
    else n_pass++;
  endtask

  task automatic test_redirect();
    int p0;
    quiesce();
    p_gnt = 100; lat_lo = 6; lat_hi = 6; p_ready = 100;
    iss_addr.delete();
    repeat (3) cycle();
    n_chk++;
    if (iss_addr.size() != 3) $display("FAIL redir_inflight got=%0d want 3", iss_addr.size());
    else n_pass++;
    p_gnt = 0; nx_en = 1; nx_addr = 32'h100;
    cycle();
    p_gnt = 100; lat_lo = 1; lat_hi = 1;
    p0 = pops;
    for (int k = 0; k < 40 && pops == p0; k++) cycle();
    n_chk++;
    if (pops == p0 || last_pop_pc !== 32'h100)
      $display("FAIL redir_target pops=%0d pc=%h want >0/00000100", pops - p0, last_pop_pc);
    else n_pass++;
    repeat (10) cycle();
  endtask

  task automatic test_priority();
    quiesce();
    nx_irq = 1; nx_ill = 1; nx_en = 1; nx_addr = 32'h100;
    cycle(); cycle();
    n_chk++;
    if (mif.req !== 1'b1 || mif.addr !== EXC) $display("FAIL prio_irq req=%b addr=%h want 1/%h", mif.req, mif.addr, EXC);
    else n_pass++;
    nx_ill = 1; nx_en = 1; nx_addr = 32'h100;
    cycle(); cycle();
    n_chk++;
    if (mif.req !== 1'b1 || mif.addr !== ILL) $display("FAIL prio_ill req=%b addr=%h want 1/%h", mif.req, mif.addr, ILL);
    else n_pass++;
    nx_en = 1; nx_addr = 32'h40;
    cycle(); cycle();
    n_chk++;
    if (mif.req !== 1'b1 || mif.addr !== 32'h40) $display("FAIL prio_jump req=%b addr=%h want 1/00000040", mif.req, mif.addr);
    else n_pass++;
  endtask

  task automatic test_random();
    int p0;
    p_gnt = 60; lat_lo = 1; lat_hi = 4; p_ready = 60; p_redir = 4;
    repeat (1500) cycle();
    p_redir = 0; p_gnt = 100; p_ready = 100; lat_lo = 1; lat_hi = 1;
    p0 = pops;
    repeat (60) cycle();
    n_chk++;
    if (pops - p0 < 30) $display("FAIL random_progress pops=%0d want >=30", pops - p0);
    else n_pass++;
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 100 && wcnt < 3; k++) @(negedge clk);
    n_chk++;
    if (wcnt < 3) $display("FAIL wrap_timeout got=%0d want 3", wcnt);
    else n_pass++;
    if (wcnt == 3) begin
      n_chk++;
      if (wcap_pc[0] !== 32'hFFFF_FFFC || wcap_pp4[0] !== 32'h0 || wcap_inst[0] !== 32'hFFFF_FFFC)
        $display("FAIL wrap_first pc=%h pp4=%h inst=%h want fffffffc/0/fffffffc", wcap_pc[0], wcap_pp4[0], wcap_inst[0]);
      else n_pass++;
      n_chk++;
      if (wcap_pc[1] !== 32'h0 || wcap_pc[2] !== 32'h4)
        $display("FAIL wrap_next pc1=%h pc2=%h want 0/4", wcap_pc[1], wcap_pc[2]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_priority();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
